// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared constants and types for the clock display subsystem: the time-set
// controller, the timekeeper and the display multiplexer all use these.
//   HOUR_W / MIN_W      : field widths for hour (0..23) and minute (0..59)
//   HOUR_MAX / MIN_MAX  : largest legal field values (wrap points)
//   state_t             : time-set controller mode encoding (visible on o_mode)
// ---------------------------------------------------------------------------
package clock_pkg;
  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_COMMIT   = 2'd3
  } state_t;
endpackage

// File: rtl/time_set_ctrl_if.sv
// ---------------------------------------------------------------------------
// time_set_ctrl_if
// Bundles every time_set_ctrl signal except clock and reset. Names are from
// the controller's point of view (i_ = into the controller, o_ = out of it).
//   master : the time-set controller
//   slave  : the surroundings (debouncers, timekeeper, display)
// Signals:
//   o_btn_ena                 debounce enable strobe
//   i_pulse_mode/up/down      debounced press pulses
//   i_cur_hour / i_cur_min    live time from the timekeeper
//   o_set_hour / o_set_min    edited time
//   o_load / i_load_ack       load request handshake to the timekeeper
//   o_run_ena                 timekeeper count enable
//   o_mode                    current controller mode
//   o_blink                   display blink gate
// ---------------------------------------------------------------------------
interface time_set_ctrl_if;
  import clock_pkg::*;

  logic              o_btn_ena;
  logic              i_pulse_mode;
  logic              i_pulse_up;
  logic              i_pulse_down;
  logic [HOUR_W-1:0] i_cur_hour;
  logic [MIN_W-1:0]  i_cur_min;
  logic [HOUR_W-1:0] o_set_hour;
  logic [MIN_W-1:0]  o_set_min;
  logic              o_load;
  logic              i_load_ack;
  logic              o_run_ena;
  logic [1:0]        o_mode;
  logic              o_blink;

  modport master (
    output o_btn_ena, o_set_hour, o_set_min, o_load, o_run_ena, o_mode, o_blink,
    input  i_pulse_mode, i_pulse_up, i_pulse_down, i_cur_hour, i_cur_min, i_load_ack
  );

  modport slave (
    input  o_btn_ena, o_set_hour, o_set_min, o_load, o_run_ena, o_mode, o_blink,
    output i_pulse_mode, i_pulse_up, i_pulse_down, i_cur_hour, i_cur_min, i_load_ack
  );
endinterface

// File: rtl/ena_prescaler.sv
// ---------------------------------------------------------------------------
// ena_prescaler
// Free-running divider producing a one-cycle enable strobe every P_DIV clock
// cycles. The count runs 0..P_DIV-1; the strobe is high while the count sits
// at P_DIV-1, so the first strobe appears P_DIV-1 cycles after reset.
// Ports:
//   i_clk  system clock
//   i_rst  asynchronous active-high reset
//   o_ena  enable strobe
// ---------------------------------------------------------------------------
module ena_prescaler #(
  parameter int P_DIV = 200000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_ena
);
  localparam int            CW   = (P_DIV > 1) ? $clog2(P_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(P_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)              r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

  assign o_ena = (r_cnt == LAST);
endmodule

// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
// Button-driven time-setting controller. Generates the shared debounce enable
// strobe, samples the debounced press pulses once per strobe, walks
// RUN -> SET_HOUR -> SET_MIN -> COMMIT, edits hour/minute with wrap-around and
// hands the result to the timekeeper over a load/ack handshake.
// Ports:
//   i_clk  system clock
//   i_rst  asynchronous active-high reset
//   bus    time_set_ctrl_if.master (see interface file for signal list)
// Parameters:
//   P_ENA_DIV        clock cycles per enable strobe
//   P_BLINK_TICKS    strobes per blink half-period
//   P_TIMEOUT_TICKS  idle strobes before an edit is abandoned
// ---------------------------------------------------------------------------
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int P_ENA_DIV       = 200000,
  parameter int P_BLINK_TICKS   = 125,
  parameter int P_TIMEOUT_TICKS = 5000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  time_set_ctrl_if.master  bus
);
  localparam int            IW        = (P_TIMEOUT_TICKS > 1) ? $clog2(P_TIMEOUT_TICKS) : 1;
  localparam int            BW        = (P_BLINK_TICKS > 1) ? $clog2(P_BLINK_TICKS) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(P_TIMEOUT_TICKS - 1);
  localparam logic [BW-1:0] BLNK_LAST = BW'(P_BLINK_TICKS - 1);

  // Wrapping up/down step; a value already above vmax (captured out of range)
  // snaps to 0 on the first step in either direction.
  function automatic logic [MIN_W-1:0] f_step(input logic [MIN_W-1:0] v,
                                              input logic [MIN_W-1:0] vmax,
                                              input logic             up);
    if (v > vmax)    return '0;
    else if (up)     return (v == vmax) ? '0 : v + 1'b1;
    else             return (v == '0) ? vmax : v - 1'b1;
  endfunction

  state_t            r_state, w_state_n;
  logic [HOUR_W-1:0] r_hour,  w_hour_n;
  logic [MIN_W-1:0]  r_min,   w_min_n;
  logic [IW-1:0]     r_idle,  w_idle_n;
  logic [BW-1:0]     r_bcnt,  w_bcnt_n;
  logic              r_blink, w_blink_n;

  logic w_tick, w_mode, w_up, w_dn, w_press;

  ena_prescaler #(.P_DIV(P_ENA_DIV)) u_presc (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_ena (w_tick)
  );

  // Pulses last a whole enable period, so sampling only on the strobe sees
  // each press once. Priority mode > up > down; up+down together cancel.
  assign w_mode  = w_tick & bus.i_pulse_mode;
  assign w_up    = w_tick & ~bus.i_pulse_mode &  bus.i_pulse_up & ~bus.i_pulse_down;
  assign w_dn    = w_tick & ~bus.i_pulse_mode & ~bus.i_pulse_up &  bus.i_pulse_down;
  assign w_press = w_mode | w_up | w_dn;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_RUN;
      r_hour  <= '0;
      r_min   <= '0;
      r_idle  <= '0;
      r_bcnt  <= '0;
      r_blink <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_hour  <= w_hour_n;
      r_min   <= w_min_n;
      r_idle  <= w_idle_n;
      r_bcnt  <= w_bcnt_n;
      r_blink <= w_blink_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_hour_n  = r_hour;
    w_min_n   = r_min;
    w_idle_n  = r_idle;
    w_bcnt_n  = r_bcnt;
    w_blink_n = r_blink;

    case (r_state)
      ST_RUN: begin
        if (w_mode) begin
          w_state_n = ST_SET_HOUR;
          w_hour_n  = bus.i_cur_hour;
          w_min_n   = bus.i_cur_min;
        end
      end

      ST_SET_HOUR, ST_SET_MIN: begin
        if (w_mode) begin
          w_state_n = (r_state == ST_SET_HOUR) ? ST_SET_MIN : ST_COMMIT;
        end else if (w_up || w_dn) begin
          if (r_state == ST_SET_HOUR)
            w_hour_n = HOUR_W'(f_step(MIN_W'(r_hour), MIN_W'(HOUR_MAX), w_up));
          else
            w_min_n  = f_step(r_min, MIN_MAX, w_up);
        end else if (w_tick && (r_idle == IDLE_LAST)) begin
          // Abandon the edit; nothing is loaded.
          w_state_n = ST_RUN;
        end

        if (w_press)     w_idle_n = '0;
        else if (w_tick) w_idle_n = r_idle + 1'b1;

        if (w_tick) begin
          if (r_bcnt == BLNK_LAST) begin
            w_bcnt_n  = '0;
            w_blink_n = ~r_blink;
          end else begin
            w_bcnt_n  = r_bcnt + 1'b1;
          end
        end
      end

      ST_COMMIT: begin
        // Presses are ignored here; only the ack (sampled every cycle) leaves.
        if (bus.i_load_ack) w_state_n = ST_RUN;
      end

      default: w_state_n = ST_RUN;
    endcase

    // Every mode change starts with a fresh timeout and the blink gate on.
    if (w_state_n != r_state) begin
      w_idle_n  = '0;
      w_bcnt_n  = '0;
      w_blink_n = 1'b1;
    end
  end

  assign bus.o_btn_ena  = w_tick;
  assign bus.o_set_hour = r_hour;
  assign bus.o_set_min  = r_min;
  assign bus.o_load     = (r_state == ST_COMMIT);
  assign bus.o_run_ena  = (r_state == ST_RUN);
  assign bus.o_mode     = r_state;
  assign bus.o_blink    = r_blink;
endmodule

// File: tb/tb_time_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_time_set_ctrl
// Directed bench for time_set_ctrl with a small prescaler (4 cycles), blink
// half-period of 2 strobes and an 8-strobe edit timeout.
// ---------------------------------------------------------------------------
module tb_time_set_ctrl;
  import clock_pkg::*;

  localparam int DIV   = 4;
  localparam int BLINK = 2;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  time_set_ctrl_if bus();

  time_set_ctrl #(
    .P_ENA_DIV       (DIV),
    .P_BLINK_TICKS   (BLINK),
    .P_TIMEOUT_TICKS (TMO)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic       m, u, d;
    int         mode;
    int         hour;
    int         min;
    int         blink;
  } vec_t;

  vec_t tbl[14];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".mode"},    int'(bus.o_mode),     0);
    chk({nm, ".load"},    int'(bus.o_load),     0);
    chk({nm, ".run_ena"}, int'(bus.o_run_ena),  1);
    chk({nm, ".hour"},    int'(bus.o_set_hour), 0);
    chk({nm, ".min"},     int'(bus.o_set_min),  0);
    chk({nm, ".blink"},   int'(bus.o_blink),    1);
    chk({nm, ".btn_ena"}, int'(bus.o_btn_ena),  0);
  endtask

  // Wait (bounded) for the strobe cycle, then return just after the edge
  // that consumes it.
  task automatic wait_tick();
    bit found = 1'b0;
    for (int i = 0; i < 2*DIV && !found; i++) begin
      @(negedge clk);
      if (bus.o_btn_ena) found = 1'b1;
    end
    if (!found) chk("tick_arrives", 0, 1);
    @(posedge clk); #1;
  endtask

  // Called just after a strobe edge: pulses stay high for exactly one period.
  task automatic step(input logic m, input logic u, input logic d);
    bus.i_pulse_mode = m;
    bus.i_pulse_up   = u;
    bus.i_pulse_down = d;
    wait_tick();
    bus.i_pulse_mode = 1'b0;
    bus.i_pulse_up   = 1'b0;
    bus.i_pulse_down = 1'b0;
  endtask

  task automatic release_rst();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Cycle 0 is the cycle right after reset release; ends aligned after the
  // strobe edge of cycle 11.
  task automatic free_run(input string nm);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) chk_reset_vals({nm, ".c0"});
      chk($sformatf("%s.ena_c%0d", nm, k), int'(bus.o_btn_ena), (k % 4 == 3) ? 1 : 0);
    end
    chk({nm, ".mode_end"}, int'(bus.o_mode), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin
    int blink_exp[7];

    bus.i_pulse_mode = 1'b0;
    bus.i_pulse_up   = 1'b0;
    bus.i_pulse_down = 1'b0;
    bus.i_cur_hour   = 5'd23;
    bus.i_cur_min    = 6'd59;
    bus.i_load_ack   = 1'b0;

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 0,  0,  0, 1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1, 23, 59, 1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1,  0, 59, 1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1, 23, 59, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1,  0, 59, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1,  0, 59, 1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 2,  0, 59, 1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 2,  0,  0, 1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 2,  0, 59, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 2,  0,  0, 0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 2,  0,  0, 1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 2,  0, 59, 1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 2,  0,  0, 0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 3,  0,  0, 1};

    blink_exp = '{1, 0, 0, 1, 1, 0, 0};

    // Reset and free-running prescaler
    #1 rst = 1'b1;
    #1 chk_reset_vals("rst_async");
    release_rst();
    free_run("run1");

    // Table: edit walk, wrap-around, cancel, mode priority into COMMIT
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].m, tbl[i].u, tbl[i].d);
      chk($sformatf("v%0d.mode", i),  int'(bus.o_mode),     tbl[i].mode);
      chk($sformatf("v%0d.hour", i),  int'(bus.o_set_hour), tbl[i].hour);
      chk($sformatf("v%0d.min", i),   int'(bus.o_set_min),  tbl[i].min);
      chk($sformatf("v%0d.blink", i), int'(bus.o_blink),    tbl[i].blink);
      chk($sformatf("v%0d.load", i),  int'(bus.o_load),     (tbl[i].mode == 3) ? 1 : 0);
      chk($sformatf("v%0d.run", i),   int'(bus.o_run_ena),  (tbl[i].mode == 0) ? 1 : 0);
    end

    // COMMIT: load held without ack, presses ignored, then ack
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("hold%0d.load", c), int'(bus.o_load), 1);
      chk($sformatf("hold%0d.mode", c), int'(bus.o_mode), 3);
    end
    step(1'b1, 1'b1, 1'b0);
    chk("commit_ign.mode", int'(bus.o_mode),    3);
    chk("commit_ign.min",  int'(bus.o_set_min), 0);
    chk("commit_ign.load", int'(bus.o_load),    1);
    @(negedge clk);
    bus.i_load_ack = 1'b1;
    @(posedge clk); #1;
    bus.i_load_ack = 1'b0;
    chk("ack.load", int'(bus.o_load),    0);
    chk("ack.mode", int'(bus.o_mode),    0);
    chk("ack.run",  int'(bus.o_run_ena), 1);

    // Timeout, with a press on the would-be timeout tick winning first
    wait_tick();
    bus.i_cur_hour = 5'd5;
    bus.i_cur_min  = 6'd30;
    step(1'b1, 1'b0, 1'b0);
    chk("to_enter.mode", int'(bus.o_mode),     1);
    chk("to_enter.hour", int'(bus.o_set_hour), 5);
    chk("to_enter.min",  int'(bus.o_set_min),  30);
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("to_a%0d.mode", k),  int'(bus.o_mode),  1);
      chk($sformatf("to_a%0d.blink", k), int'(bus.o_blink), blink_exp[k]);
      chk($sformatf("to_a%0d.load", k),  int'(bus.o_load),  0);
    end
    step(1'b0, 1'b1, 1'b0);
    chk("to_press.mode", int'(bus.o_mode),     1);
    chk("to_press.hour", int'(bus.o_set_hour), 6);
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("to_b%0d.mode", k), int'(bus.o_mode), 1);
      chk($sformatf("to_b%0d.load", k), int'(bus.o_load), 0);
    end
    step(1'b0, 1'b0, 1'b0);
    chk("to_fire.mode",  int'(bus.o_mode),    0);
    chk("to_fire.load",  int'(bus.o_load),    0);
    chk("to_fire.run",   int'(bus.o_run_ena), 1);
    chk("to_fire.blink", int'(bus.o_blink),   1);

    // Out-of-range capture clamps, then reset in the middle of COMMIT
    bus.i_cur_hour = 5'd30;
    bus.i_cur_min  = 6'd62;
    step(1'b1, 1'b0, 1'b0);
    chk("clamp_cap.hour", int'(bus.o_set_hour), 30);
    chk("clamp_cap.min",  int'(bus.o_set_min),  62);
    step(1'b0, 1'b0, 1'b1);
    chk("clamp_dn.hour",  int'(bus.o_set_hour), 0);
    step(1'b1, 1'b0, 1'b0);
    chk("clamp_sm.mode",  int'(bus.o_mode),     2);
    step(1'b0, 1'b1, 1'b0);
    chk("clamp_up.min",   int'(bus.o_set_min),  0);
    step(1'b1, 1'b0, 1'b0);
    chk("rc_commit.load", int'(bus.o_load),     1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1 chk_reset_vals("rst_commit");
    release_rst();
    free_run("run2");
    chk("post_rst.load", int'(bus.o_load), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
